// File: rtl/circular_buffer_drain_if.sv
// Producer/consumer bus of the draining ring buffer.
// The slave modport is the buffer itself; the master modport drives it.
interface circular_buffer_drain_if #(
    parameter int N = 6,
    parameter int W = 32
);
    logic         flush_i;
    logic         write_i;
    logic [W-1:0] data_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] data_o;
    logic [N:0]   count_o;
    logic         overflow_o;
    logic [15:0]  drop_cnt_o;

    modport slave (
        input  flush_i, write_i, data_i, ready_i,
        output valid_o, data_o, count_o, overflow_o, drop_cnt_o
    );

    modport master (
        output flush_i, write_i, data_i, ready_i,
        input  valid_o, data_o, count_o, overflow_o, drop_cnt_o
    );
endinterface

// File: rtl/circular_buffer_drain.sv
// Ring buffer that never stalls its producer and drains oldest-first.
// When it is full, the oldest entry is overwritten and the loss is counted.
module circular_buffer_drain #(
    parameter int N = 6,
    parameter int W = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    circular_buffer_drain_if.slave bus
);
    localparam int         DEPTH      = 1 << N;
    localparam logic [N:0] FULL_COUNT = DEPTH[N:0];

    logic [W-1:0] r_mem [DEPTH];
    logic [N-1:0] r_wp;
    logic [N-1:0] r_rp;
    logic [N:0]   r_count;
    logic         r_overflow;
    logic [15:0]  r_drop_cnt;

    logic w_valid;
    logic w_pop;
    logic w_full;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & bus.ready_i;
    assign w_full  = (r_count == FULL_COUNT);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.flush_i) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (bus.write_i) begin
                r_mem[r_wp] <= bus.data_i;
                r_wp        <= r_wp + N'(1);
            end
            // A write into a full ring with no pop evicts the oldest entry.
            if (bus.write_i && w_full && !w_pop) begin
                r_rp       <= r_rp + N'(1);
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end else if (bus.write_i && w_pop) begin
                r_rp <= r_rp + N'(1);
            end else if (bus.write_i) begin
                r_count <= r_count + (N+1)'(1);
            end else if (w_pop) begin
                r_rp    <= r_rp + N'(1);
                r_count <= r_count - (N+1)'(1);
            end
        end
    end

    assign bus.valid_o    = w_valid;
    assign bus.data_o     = r_mem[r_rp];
    assign bus.count_o    = r_count;
    assign bus.overflow_o = r_overflow;
    assign bus.drop_cnt_o = r_drop_cnt;
endmodule

// File: tb/tb_circular_buffer_drain.sv
// Directed and randomized checks of circular_buffer_drain against a queue model.
module tb_circular_buffer_drain;
    localparam int N     = 6;
    localparam int W     = 32;
    localparam int DEPTH = 1 << N;

    logic clk_i = 1'b0;
    logic rst_ni;

    circular_buffer_drain_if #(.N(N), .W(W)) bus ();

    circular_buffer_drain #(.N(N), .W(W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    logic [W-1:0] modelQ[$];
    logic         modelOverflow;
    logic [15:0]  modelDrops;
    int checks   = 0;
    int failures = 0;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".valid"}, 32'(bus.valid_o), 32'(modelQ.size() != 0));
        checkValue({tag, ".count"}, 32'(bus.count_o), 32'(modelQ.size()));
        checkValue({tag, ".overflow"}, 32'(bus.overflow_o), 32'(modelOverflow));
        checkValue({tag, ".drops"}, 32'(bus.drop_cnt_o), 32'(modelDrops));
        if (modelQ.size() != 0) begin
            checkValue({tag, ".data"}, bus.data_o, modelQ[0]);
        end
    endtask

    // Drive one cycle, advance the model by the behavioural rules, then sample.
    task automatic applyStimulus(input logic rst, input logic flush, input logic wr,
                                 input logic [W-1:0] data, input logic rdy,
                                 input bit doCheck, input string tag);
        bit popNow;
        rst_ni      = rst;
        bus.flush_i = flush;
        bus.write_i = wr;
        bus.data_i  = data;
        bus.ready_i = rdy;
        popNow = rdy && (modelQ.size() != 0);
        @(posedge clk_i);
        #1;
        if (!rst || flush) begin
            modelQ.delete();
            modelOverflow = 1'b0;
            modelDrops    = '0;
        end else begin
            if (popNow) void'(modelQ.pop_front());
            if (wr) begin
                if (modelQ.size() == DEPTH) begin
                    void'(modelQ.pop_front());
                    modelOverflow = 1'b1;
                    if (modelDrops != 16'hFFFF) modelDrops++;
                end
                modelQ.push_back(data);
            end
        end
        if (doCheck) checkOutput(tag);
    endtask

    initial begin
        modelOverflow = 1'b0;
        modelDrops    = '0;

        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "reset");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h1234, 1'b1, 1'b1, "reset");
        checkValue("reset.data_zero", bus.data_o, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, "single_wr");
        checkValue("single_wr.data_const", bus.data_o, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, "single_pop");
        checkValue("single_pop.valid_const", 32'(bus.valid_o), 32'h0);

        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b1, W'(i), 1'b0, 1'b1, "fill");
            checkValue("fill.count_const", 32'(bus.count_o), 32'd64);
            for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, "drain");
        end

        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b1, W'(i), 1'b0, 1'b1, "ovw_fill");
        for (int i = 100; i < 103; i++) applyStimulus(1'b1, 1'b0, 1'b1, W'(i), 1'b0, 1'b1, "ovw");
        checkValue("ovw.drops_const", 32'(bus.drop_cnt_o), 32'd3);
        checkValue("ovw.data_const", bus.data_o, 32'd3);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h55, 1'b1, 1'b1, "flush_prio");
        checkValue("flush_prio.count_const", 32'(bus.count_o), 32'd0);

        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b1, W'(i), 1'b0, 1'b1, "ovw_fill2");
        for (int i = 100; i < 103; i++) applyStimulus(1'b1, 1'b0, 1'b1, W'(i), 1'b0, 1'b1, "ovw2");
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, "ovw_drain");

        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b1, W'(i), 1'b0, 1'b1, "fullrw_fill");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd64, 1'b1, 1'b1, "full_wr_pop");
        checkValue("full_wr_pop.data_const", bus.data_o, 32'd1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b1, W'(200 + i), 1'b1, 1'b1, "stream");

        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 9) < 4),
                          1'b1, "random");
        end

        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, "sat_flush");
        for (int i = 0; i < DEPTH + 70000; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, W'(i + 7), 1'b0, (i % 5000 == 0), "sat");
        end
        checkOutput("sat_end");
        checkValue("sat.drops_const", 32'(bus.drop_cnt_o), 32'h0000FFFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hABCD, 1'b1, 1'b1, "rst_mid");
        checkValue("rst_mid.data_zero", bus.data_o, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h77, 1'b0, 1'b1, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
